// File: rtl/seq_add_sub_unit.sv
// seq_add_sub_unit: multi-cycle two's-complement adder/subtractor.
// Processes CHUNK bits per cycle LSB-first with a registered ripple carry,
// trading N = WIDTH/CHUNK cycles of latency for a short carry chain.
module seq_add_sub_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Latched operands; b is stored already inverted for subtract.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_eff_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             carry_chunk;
    logic             last_chunk;

    // One CHUNK-wide slice of the ripple adder, carry in the top bit.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Signed overflow: same-sign operands producing a sum of the other sign.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Select the active chunk and add it with the held carry.
    always_comb begin
        a_chunk                  = a_q[int'(k_q)*CHUNK +: CHUNK];
        b_chunk                  = b_eff_q[int'(k_q)*CHUNK +: CHUNK];
        {carry_chunk, sum_chunk} = chunk_add(a_chunk, b_chunk, carry_q);
        last_chunk               = (k_q == K_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; in_valid only matters in IDLE, out_ready only in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs and zero flag decoded from state and result register.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        zero      = (state == DONE) && (result == '0);
    end

    // Operand capture, per-chunk result write and final flag capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_eff_q   <= '0;
            carry_q   <= 1'b0;
            k_q       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_eff_q <= op ? ~b : b;
                        carry_q <= op;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    result[int'(k_q)*CHUNK +: CHUNK] <= sum_chunk;
                    carry_q <= carry_chunk;
                    k_q     <= k_q + 1'b1;
                    if (last_chunk) begin
                        carry_out <= carry_chunk;
                        overflow  <= signed_ovf(a_q[WIDTH-1], b_eff_q[WIDTH-1],
                                                sum_chunk[CHUNK-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Scoreboard bench for seq_add_sub_unit: directed cases on the 64/16 instance,
// then random add/sub sweeps over four other WIDTH/CHUNK configurations.
module tb_seq_add_sub_unit;

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    localparam int NVEC = 250;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  iv;
    logic [4:0]  opv;
    logic [4:0]  ordy;
    logic [63:0] av [5];
    logic [63:0] bv [5];
    wire  [4:0]  ir;
    wire  [4:0]  ov;
    wire  [4:0]  co;
    wire  [4:0]  ovf;
    wire  [4:0]  zr;
    wire  [63:0] rv [4];
    wire  [31:0] r32;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];

    int cfg_w [5] = '{64, 64, 64, 64, 32};
    int cfg_n [5] = '{4, 64, 8, 1, 4};

    always #5 clk = ~clk;

    seq_add_sub_unit #(.WIDTH(64), .CHUNK(16)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
        .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(rv[0]),
        .carry_out(co[0]), .overflow(ovf[0]), .zero(zr[0]));
    seq_add_sub_unit #(.WIDTH(64), .CHUNK(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
        .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(rv[1]),
        .carry_out(co[1]), .overflow(ovf[1]), .zero(zr[1]));
    seq_add_sub_unit #(.WIDTH(64), .CHUNK(8)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .op(opv[2]),
        .a(av[2]), .b(bv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .result(rv[2]),
        .carry_out(co[2]), .overflow(ovf[2]), .zero(zr[2]));
    seq_add_sub_unit #(.WIDTH(64), .CHUNK(64)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]), .op(opv[3]),
        .a(av[3]), .b(bv[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .result(rv[3]),
        .carry_out(co[3]), .overflow(ovf[3]), .zero(zr[3]));
    seq_add_sub_unit #(.WIDTH(32), .CHUNK(8)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv[4]), .in_ready(ir[4]), .op(opv[4]),
        .a(av[4][31:0]), .b(bv[4][31:0]), .out_valid(ov[4]), .out_ready(ordy[4]),
        .result(r32), .carry_out(co[4]), .overflow(ovf[4]), .zero(zr[4]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] res_of(input int sel);
        return (sel == 4) ? {32'h0, r32} : rv[sel];
    endfunction

    // Reference: add/sub on w-bit values, signed overflow judged on original operand signs.
    function automatic exp_t model(input int w, input bit o, input logic [63:0] x,
                                   input logic [63:0] y);
        exp_t        e;
        logic [64:0] mask, xe, ye, s;
        logic        sa, sb, sr;
        mask = (65'd1 << w) - 65'd1;
        xe   = {1'b0, x} & mask;
        ye   = {1'b0, y} & mask;
        s    = o ? (xe + ((~ye) & mask) + 65'd1) : (xe + ye);
        e.r  = s[63:0] & mask[63:0];
        e.c  = s[w];
        sa   = xe[w-1];
        sb   = ye[w-1];
        sr   = e.r[w-1];
        e.v  = o ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e.z  = (e.r == 64'd0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] r, input bit c, input bit v, input bit z);
        exp_t e;
        e.r = r; e.c = c; e.v = v; e.z = z;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] t;
        case ($urandom_range(0, 11))
            0:       t = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       t = 64'h7FFF_FFFF_FFFF_FFFF;
            2:       t = 64'h8000_0000_0000_0000;
            3:       t = 64'h0000_0000_FFFF_FFFF;
            4:       t = 64'h0;
            5:       t = 64'h0000_0000_7FFF_FFFF;
            6:       t = 64'h0000_0000_8000_0000;
            default: t = {$urandom, $urandom};
        endcase
        return t;
    endfunction

    // Wait for in_ready, optionally push the expectation, then present one accept edge.
    task automatic send(input int sel, input bit o, input logic [63:0] x, input logic [63:0] y,
                        input bit push, input exp_t e);
        int g = 0;
        while (!ir[sel] && g < 300) begin
            @(posedge clk); #1; g++;
        end
        chk("in_ready_before_accept", 64'(ir[sel]), 64'd1);
        if (push) sbq.push_back(e);
        opv[sel] = o; av[sel] = x; bv[sel] = y; iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid, bounded.
    task automatic wait_done(input int sel);
        int lat = 0;
        while (!ov[sel] && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'(cfg_n[sel]));
    endtask

    // Pop the scoreboard, compare, then complete the output handshake.
    task automatic collect(input int sel);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sbq.pop_front();
        chk("out_valid", 64'(ov[sel]), 64'd1);
        chk("result", res_of(sel), e.r);
        chk("carry_out", 64'(co[sel]), 64'(e.c));
        chk("overflow", 64'(ovf[sel]), 64'(e.v));
        chk("zero", 64'(zr[sel]), 64'(e.z));
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        chk("out_valid_after_release", 64'(ov[sel]), 64'd0);
        chk("in_ready_after_release", 64'(ir[sel]), 64'd1);
    endtask

    task automatic op_check(input int sel, input bit o, input logic [63:0] x,
                            input logic [63:0] y, input exp_t e);
        send(sel, o, x, y, 1'b1, e);
        wait_done(sel);
        collect(sel);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [63:0] x, y;
        bit          o;

        reset = 1'b1; iv = '0; opv = '0; ordy = '0;
        for (int i = 0; i < 5; i++) begin av[i] = '0; bv[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(ir), 64'h1F);
        chk("rst_out_valid", 64'(ov), 64'h0);
        chk("rst_result", rv[0], 64'h0);
        chk("rst_flags", {61'h0, co[0], ovf[0], zr[0]}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases, expected values written out literally.
        op_check(0, 1'b0, 64'd1, 64'd1, mk(64'd2, 0, 0, 0));
        op_check(0, 1'b1, 64'd5, 64'd7, mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0));
        op_check(0, 1'b1, 64'd7, 64'd5, mk(64'd2, 1, 0, 0));
        op_check(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, mk(64'h8000_0000_0000_0000, 0, 1, 0));
        op_check(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(64'd0, 1, 0, 1));

        // Backpressure: DONE held with out_ready low while in_valid toggles.
        send(0, 1'b0, 64'h1234, 64'h1111, 1'b1, mk(64'h2345, 0, 0, 0));
        wait_done(0);
        for (int i = 0; i < 10; i++) begin
            iv[0] = i[0]; av[0] = {$urandom, $urandom}; bv[0] = {$urandom, $urandom};
            opv[0] = i[1];
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(ov[0]), 64'd1);
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
            chk("bp_result", rv[0], 64'h2345);
            chk("bp_flags", {61'h0, co[0], ovf[0], zr[0]}, 64'h0);
        end
        iv[0] = 1'b0;
        collect(0);
        op_check(0, 1'b1, 64'h100, 64'h1, mk(64'hFF, 1, 0, 0));

        // out_ready held high outside DONE must not shorten the operation.
        ordy[0] = 1'b1;
        send(0, 1'b0, 64'h10, 64'h20, 1'b1, mk(64'h30, 0, 0, 0));
        wait_done(0);
        collect(0);

        // Reset two cycles into RUN discards the operation.
        send(0, 1'b0, 64'hDEAD, 64'hBEEF, 1'b0, mk(64'h0, 0, 0, 0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", 64'(ir[0]), 64'd1);
        chk("midrst_out_valid", 64'(ov[0]), 64'd0);
        chk("midrst_result", rv[0], 64'h0);
        chk("midrst_flags", {61'h0, co[0], ovf[0], zr[0]}, 64'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", 64'(ov[0]), 64'd0);
        end
        op_check(0, 1'b1, 64'd0, 64'd1, mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0));

        // Random sweep across the other configurations against the model.
        for (int sel = 1; sel < 5; sel++) begin
            for (int n = 0; n < NVEC; n++) begin
                x = rnd64();
                y = rnd64();
                o = $urandom_range(0, 1) == 1;
                e = model(cfg_w[sel], o, x, y);
                op_check(sel, o, x, y, e);
            end
        end

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
